// File: rtl/kmeans_ctrl_k3_d5.sv
// kmeans_ctrl_k3_d5: one k-means assignment/accumulation pass for K=3
// clusters over D=5 dimensions, wrapped around an external distance pipeline.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   cfg_we/k/d/data       centroid register write (accepted in IDLE only)
//   start, num_points     begin a pass over num_points points (IDLE or DONE)
//   in_valid/in_ready     point stream handshake, in_data = 5 packed dims
//   pipe_centroids        all centroid registers, k-major (k*5+d)
//   pipe_data_in          in_data passed straight to the distance pipeline
//   pipe_sel/data_out     pipeline result: chosen centroid and echoed point
//   rd_k, rd_d            result read address
//   rd_sum, rd_cnt        per-cluster sums and counts (0 when out of range)
//   busy, done, sel_err   status: RUN/DRAIN, pass-complete pulse, bad sel seen
module kmeans_ctrl_k3_d5 #(
    parameter int input_data_width  = 16,
    parameter int centroid_id_width = 2,
    parameter int pipe_latency      = 7,
    parameter int acc_width         = 32,
    parameter int cnt_width         = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            cfg_we,
    input  logic [1:0]                      cfg_k,
    input  logic [2:0]                      cfg_d,
    input  logic [input_data_width-1:0]     cfg_data,
    input  logic                            start,
    input  logic [cnt_width-1:0]            num_points,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [5*input_data_width-1:0]   in_data,
    output logic [15*input_data_width-1:0]  pipe_centroids,
    output logic [5*input_data_width-1:0]   pipe_data_in,
    input  logic [centroid_id_width-1:0]    pipe_sel,
    input  logic [5*input_data_width-1:0]   pipe_data_out,
    input  logic [1:0]                      rd_k,
    input  logic [2:0]                      rd_d,
    output logic [acc_width-1:0]            rd_sum,
    output logic [cnt_width-1:0]            rd_cnt,
    output logic                            busy,
    output logic                            done,
    output logic                            sel_err
);
    localparam int W = input_data_width;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

    state_t                  state_q;
    logic [W-1:0]            cent_q  [15];
    logic [acc_width-1:0]    sum_q   [3][5];
    logic [cnt_width-1:0]    count_q [3];
    logic [cnt_width-1:0]    num_q;
    logic [cnt_width-1:0]    issued_q;
    logic [cnt_width-1:0]    issued_nxt;
    logic [pipe_latency-1:0] vld_sr;
    logic                    busy_q;
    logic                    done_q;
    logic                    sel_err_q;
    logic                    xfer;
    logic                    res_valid;

    assign in_ready     = (state_q == ST_RUN) && (issued_q < num_q);
    assign xfer         = in_valid && in_ready;
    assign issued_nxt   = issued_q + cnt_width'(xfer);
    assign res_valid    = vld_sr[pipe_latency-1];
    assign pipe_data_in = in_data;
    assign busy         = busy_q;
    assign done         = done_q;
    assign sel_err      = sel_err_q;

    always_comb begin
        pipe_centroids = '0;
        for (int unsigned i = 0; i < 15; i++)
            pipe_centroids[i*W +: W] = cent_q[i];
    end

    always_comb begin
        rd_sum = '0;
        rd_cnt = '0;
        for (int unsigned k = 0; k < 3; k++) begin
            if (rd_k == 2'(k)) begin
                rd_cnt = count_q[k];
                for (int unsigned d = 0; d < 5; d++)
                    if (rd_d == 3'(d))
                        rd_sum = sum_q[k][d];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            num_q     <= '0;
            issued_q  <= '0;
            vld_sr    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sel_err_q <= 1'b0;
            for (int unsigned i = 0; i < 15; i++)
                cent_q[i] <= '0;
            for (int unsigned k = 0; k < 3; k++) begin
                count_q[k] <= '0;
                for (int unsigned d = 0; d < 5; d++)
                    sum_q[k][d] <= '0;
            end
        end else begin
            // Valid tracker runs in every state so results line up with the
            // external pipeline regardless of FSM position.
            vld_sr <= {vld_sr[pipe_latency-2:0], xfer};
            done_q <= 1'b0;

            if (res_valid) begin
                if (pipe_sel >= centroid_id_width'(3))
                    sel_err_q <= 1'b1;
                for (int unsigned k = 0; k < 3; k++) begin
                    if (pipe_sel == centroid_id_width'(k)) begin
                        count_q[k] <= count_q[k] + cnt_width'(1);
                        for (int unsigned d = 0; d < 5; d++)
                            sum_q[k][d] <= sum_q[k][d]
                                + acc_width'(pipe_data_out[d*W +: W]);
                    end
                end
            end

            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (state_q == ST_IDLE && cfg_we)
                        for (int unsigned k = 0; k < 3; k++)
                            for (int unsigned d = 0; d < 5; d++)
                                if (cfg_k == 2'(k) && cfg_d == 3'(d))
                                    cent_q[k*5+d] <= cfg_data;
                    if (start) begin
                        state_q   <= ST_RUN;
                        busy_q    <= 1'b1;
                        num_q     <= num_points;
                        issued_q  <= '0;
                        sel_err_q <= 1'b0;
                        for (int unsigned k = 0; k < 3; k++) begin
                            count_q[k] <= '0;
                            for (int unsigned d = 0; d < 5; d++)
                                sum_q[k][d] <= '0;
                        end
                    end
                end
                ST_RUN: begin
                    issued_q <= issued_nxt;
                    // Compared after the increment, so a zero-point pass
                    // leaves RUN on its first cycle.
                    if (issued_nxt == num_q)
                        state_q <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (vld_sr == '0) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_kmeans_ctrl_k3_d5.sv
// tb_kmeans_ctrl_k3_d5: directed self-checking bench for kmeans_ctrl_k3_d5.
// A behavioural delay line stands in for the distance pipeline; the centroid
// choice for each point is supplied by the stimulus tables.
module tb_kmeans_ctrl_k3_d5;
    localparam int W  = 16;
    localparam int L  = 7;
    localparam int AW = 32;
    localparam int CW = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            cfg_we;
    logic [1:0]      cfg_k;
    logic [2:0]      cfg_d;
    logic [W-1:0]    cfg_data;
    logic            start;
    logic [CW-1:0]   num_points;
    logic            in_valid;
    logic            in_ready;
    logic [5*W-1:0]  in_data;
    logic [15*W-1:0] pipe_centroids;
    logic [5*W-1:0]  pipe_data_in;
    logic [1:0]      pipe_sel;
    logic [5*W-1:0]  pipe_data_out;
    logic [1:0]      rd_k;
    logic [2:0]      rd_d;
    logic [AW-1:0]   rd_sum;
    logic [CW-1:0]   rd_cnt;
    logic            busy;
    logic            done;
    logic            sel_err;

    always #5 clk = ~clk;

    kmeans_ctrl_k3_d5 #(
        .input_data_width(W), .centroid_id_width(2), .pipe_latency(L),
        .acc_width(AW), .cnt_width(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_k(cfg_k), .cfg_d(cfg_d),
        .cfg_data(cfg_data), .start(start), .num_points(num_points),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .pipe_centroids(pipe_centroids), .pipe_data_in(pipe_data_in),
        .pipe_sel(pipe_sel), .pipe_data_out(pipe_data_out),
        .rd_k(rd_k), .rd_d(rd_d), .rd_sum(rd_sum), .rd_cnt(rd_cnt),
        .busy(busy), .done(done), .sel_err(sel_err)
    );

    // Distance pipeline stand-in: fixed L-cycle delay of point and chosen id.
    logic [1:0]     cur_sel;
    logic [1:0]     msel [L];
    logic [5*W-1:0] mdat [L];
    always @(posedge clk) begin
        msel[0] <= cur_sel;
        mdat[0] <= in_data;
        for (int i = 1; i < L; i++) begin
            msel[i] <= msel[i-1];
            mdat[i] <= mdat[i-1];
        end
    end
    assign pipe_sel      = msel[L-1];
    assign pipe_data_out = mdat[L-1];

    // Edge-level event monitor.
    int cyc = 0, xfer_cnt = 0, last_xfer = 0, done_cnt = 0, done_edge = 0;
    int busy_cyc = 0, ready_cnt = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (in_valid && in_ready) begin
            xfer_cnt  <= xfer_cnt + 1;
            last_xfer <= cyc + 1;
        end
        if (done) begin
            done_cnt  <= done_cnt + 1;
            done_edge <= cyc;
        end
        if (busy)     busy_cyc  <= busy_cyc + 1;
        if (in_ready) ready_cnt <= ready_cnt + 1;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    logic [5*W-1:0] pt_val [8];
    logic [1:0]     pt_sel [8];

    function automatic logic [5*W-1:0] mk(input int base, input int step);
        logic [5*W-1:0] r;
        r = '0;
        for (int d = 0; d < 5; d++) r[d*W +: W] = W'(base + step*d);
        return r;
    endfunction

    function automatic logic [W-1:0] cent(input int k, input int d);
        return pipe_centroids[(k*5+d)*W +: W];
    endfunction

    task automatic cfg_write(input int k, input int d, input int data);
        @(negedge clk);
        cfg_we = 1'b1; cfg_k = 2'(k); cfg_d = 3'(d); cfg_data = W'(data);
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic start_pass(input int n);
        @(negedge clk);
        start = 1'b1; num_points = CW'(n);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic stream(input int n, input bit toggle);
        int idx = 0;
        int guard = 0;
        while (idx < n && guard < 200) begin
            @(negedge clk);
            guard++;
            in_data  = pt_val[idx];
            cur_sel  = pt_sel[idx];
            in_valid = toggle ? (guard % 2 == 0) : 1'b1;
            if (in_valid && in_ready) idx++;
        end
        if (idx != n) check("stream_timeout", 64'(idx), 64'(n));
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic chk_sum(input string tag, input int k, input int d, input int exp);
        rd_k = 2'(k); rd_d = 3'(d);
        #1;
        check(tag, 64'(rd_sum), 64'(exp));
    endtask

    task automatic chk_cnt(input string tag, input int k, input int exp);
        rd_k = 2'(k); rd_d = 3'd0;
        #1;
        check(tag, 64'(rd_cnt), 64'(exp));
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int d0, b0, r0, x0;
        logic [15*W-1:0] exp_cent;
        rst_n = 1'b0; cfg_we = 1'b0; cfg_k = '0; cfg_d = '0; cfg_data = '0;
        start = 1'b0; num_points = '0; in_valid = 1'b0; in_data = '0;
        cur_sel = '0; rd_k = '0; rd_d = '0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_in_ready", 64'(in_ready), 0);
        check("rst_busy",     64'(busy), 0);
        check("rst_done",     64'(done), 0);
        check("rst_sel_err",  64'(sel_err), 0);
        check("rst_cent_zero", 64'(pipe_centroids == '0), 1);
        rst_n = 1'b1;

        // Centroid load, including ignored out-of-range addresses
        exp_cent = '0;
        for (int k = 0; k < 3; k++)
            for (int d = 0; d < 5; d++) begin
                cfg_write(k, d, k*100);
                exp_cent[(k*5+d)*W +: W] = W'(k*100);
            end
        cfg_write(3, 0, 777);
        cfg_write(1, 5, 777);
        check("cent_all", 64'(pipe_centroids == exp_cent), 1);
        check("cent_1_3", 64'(cent(1, 3)), 100);
        check("cent_2_4", 64'(cent(2, 4)), 200);

        // Basic three-point pass; a cfg write during RUN must be ignored
        pt_val[0] = mk(1, 0);   pt_sel[0] = 2'd0;
        pt_val[1] = mk(99, 0);  pt_sel[1] = 2'd1;
        pt_val[2] = mk(210, 0); pt_sel[2] = 2'd2;
        d0 = done_cnt;
        start_pass(3);
        check("run_busy", 64'(busy), 1);
        cfg_we = 1'b1; cfg_k = 2'd1; cfg_d = 3'd0; cfg_data = W'(555);
        in_data = mk(1234, 3);
        #1;
        check("pass_through", 64'(pipe_data_in == mk(1234, 3)), 1);
        @(negedge clk);
        cfg_we = 1'b0;
        check("cent_run_write", 64'(cent(1, 0)), 100);
        stream(3, 1'b0);
        repeat (L + 6) @(negedge clk);
        check("p1_done_once", 64'(done_cnt - d0), 1);
        check("p1_busy_end", 64'(busy), 0);
        chk_cnt("p1_cnt0", 0, 1);
        chk_cnt("p1_cnt1", 1, 1);
        chk_cnt("p1_cnt2", 2, 1);
        chk_sum("p1_sum20", 2, 0, 210);
        chk_sum("p1_sum14", 1, 4, 99);
        chk_sum("p1_sum02", 0, 2, 1);
        check("p1_sel_err", 64'(sel_err), 0);

        // Zero-point pass started from DONE
        d0 = done_cnt; b0 = busy_cyc; r0 = ready_cnt;
        start_pass(0);
        repeat (6) @(negedge clk);
        check("z_busy_cycles", 64'(busy_cyc - b0), 2);
        check("z_done_once",   64'(done_cnt - d0), 1);
        check("z_no_ready",    64'(ready_cnt - r0), 0);
        chk_cnt("z_cnt0", 0, 0);
        chk_cnt("z_cnt1", 1, 0);
        chk_cnt("z_cnt2", 2, 0);

        // Invalid selection excluded and flagged
        pt_val[0] = mk(5, 0); pt_sel[0] = 2'd0;
        pt_val[1] = mk(6, 0); pt_sel[1] = 2'd3;
        pt_val[2] = mk(7, 0); pt_sel[2] = 2'd2;
        d0 = done_cnt;
        start_pass(3);
        stream(3, 1'b0);
        repeat (L + 6) @(negedge clk);
        check("se_done_once", 64'(done_cnt - d0), 1);
        check("se_sel_err", 64'(sel_err), 1);
        chk_cnt("se_cnt0", 0, 1);
        chk_cnt("se_cnt1", 1, 0);
        chk_cnt("se_cnt2", 2, 1);
        chk_sum("se_sum00", 0, 0, 5);
        chk_sum("se_sum21", 2, 1, 7);
        chk_sum("se_sum10", 1, 0, 0);
        chk_cnt("rd_k3_cnt", 3, 0);
        chk_sum("rd_k3_sum", 3, 0, 0);
        chk_sum("rd_d5_sum", 0, 5, 0);

        // Four points with in_valid toggling; latency to done
        for (int p = 0; p < 4; p++) pt_val[p] = mk(10*(p+1), 1);
        pt_sel[0] = 2'd0; pt_sel[1] = 2'd1; pt_sel[2] = 2'd2; pt_sel[3] = 2'd0;
        d0 = done_cnt; x0 = xfer_cnt;
        start_pass(4);
        stream(4, 1'b1);
        check("t_ready_drop", 64'(in_ready), 0);
        repeat (L + 6) @(negedge clk);
        check("t_xfers", 64'(xfer_cnt - x0), 4);
        check("t_done_once", 64'(done_cnt - d0), 1);
        check("t_done_latency", 64'(done_edge - last_xfer), 64'(L + 1));
        check("t_sel_err_clr", 64'(sel_err), 0);
        chk_cnt("t_cnt0", 0, 2);
        chk_sum("t_sum03", 0, 3, 56);
        chk_sum("t_sum10", 1, 0, 20);
        chk_sum("t_sum24", 2, 4, 34);

        // Reset during DRAIN discards in-flight results
        pt_val[0] = mk(3, 0); pt_sel[0] = 2'd1;
        pt_val[1] = mk(4, 0); pt_sel[1] = 2'd2;
        d0 = done_cnt;
        start_pass(2);
        stream(2, 1'b0);
        @(negedge clk);
        check("dr_busy", 64'(busy), 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("dr_busy_rst",  64'(busy), 0);
        check("dr_done_rst",  64'(done), 0);
        check("dr_ready_rst", 64'(in_ready), 0);
        check("dr_cent_rst",  64'(pipe_centroids == '0), 1);
        repeat (L + 6) @(negedge clk);
        check("dr_no_done", 64'(done_cnt - d0), 0);
        chk_cnt("dr_cnt1", 1, 0);
        chk_cnt("dr_cnt2", 2, 0);

        d0 = done_cnt;
        start_pass(2);
        stream(2, 1'b0);
        repeat (L + 6) @(negedge clk);
        check("ar_done_once", 64'(done_cnt - d0), 1);
        chk_cnt("ar_cnt0", 0, 0);
        chk_cnt("ar_cnt1", 1, 1);
        chk_cnt("ar_cnt2", 2, 1);
        chk_sum("ar_sum10", 1, 0, 3);
        chk_sum("ar_sum20", 2, 0, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/kmeans_ctrl_k3_d5.md
KMEANS_CTRL_K3_D5 -- requirements
Module: kmeans_ctrl_k3_d5

Interface
REQ-001 SHALL have parameter input_data_width, default 16, meaning the width of one point/centroid dimension.
REQ-002 SHALL have parameter centroid_id_width, default 2, meaning the width of a centroid index.
REQ-003 SHALL have parameter pipe_latency, default 7, meaning the cycles from point issue to result at the distance pipeline.
REQ-004 SHALL have parameter acc_width, default 32, meaning the width of the per-cluster, per-dimension sum accumulators.
REQ-005 SHALL have parameter cnt_width, default 16, meaning the width of the point counter and the cluster counters.
REQ-006 clk  in  1  single clock; all state changes on rising edge.
REQ-007 rst_n  in  1  reset, synchronous, active-low.
REQ-008 cfg_we  in  1  centroid write strobe; honoured only in IDLE.
REQ-009 cfg_k  in  2  centroid index 0..2; value 3 is ignored.
REQ-010 cfg_d  in  3  dimension index 0..4; values 5..7 are ignored.
REQ-011 cfg_data  in  input_data_width  centroid coordinate.
REQ-012 start  in  1  begin one clustering pass; sampled in IDLE or DONE.
REQ-013 num_points  in  cnt_width  points in the pass; latched on start.
REQ-014 in_valid / in_ready  in / out  1 / 1  point stream handshake.
REQ-015 in_data  in  5*input_data_width  point; dimension d occupies bits [d*W +: W].
REQ-016 pipe_centroids  out  15*W  centroid registers, k-major (k*5+d); drives the distance pipeline.
REQ-017 pipe_data_in  out  5*W  equals in_data (combinational pass-through).
REQ-018 pipe_sel  in  2  selected centroid from the pipeline.
REQ-019 pipe_data_out  in  5*W  point echoed by the pipeline, aligned with pipe_sel.
REQ-020 rd_k, rd_d  in  2, 3  result read address.
REQ-021 rd_sum  out  acc_width  sum[rd_k][rd_d], combinational; 0 when the address is out of range.
REQ-022 rd_cnt  out  cnt_width  count[rd_k], combinational; 0 when rd_k=3.
REQ-023 busy  out  1  high in RUN and DRAIN.
REQ-024 done  out  1  one-cycle pulse when a pass completes.
REQ-025 sel_err  out  1  sticky flag: pipe_sel=3 was seen on a valid result this pass.

Function
REQ-026 SHALL implement FSM states IDLE, RUN, DRAIN and DONE.
REQ-027 IDLE to RUN on start=1; the same cycle SHALL latch num_points, zero all sums, counts, the issued counter and sel_err.
REQ-028 RUN: in_ready=1 iff issued<num_latched; each accepted transfer (in_valid&in_ready) SHALL increment issued.
REQ-029 RUN to DRAIN in the cycle issued reaches num_latched (counted after the increment); num_points=0 SHALL go RUN to DRAIN on the first RUN cycle.
REQ-030 SHALL keep a pipe_latency-deep valid shift register, shifting every cycle in every state; its input SHALL be the accepted-transfer flag.
REQ-031 The result for a point accepted in cycle t SHALL be valid on pipe_sel/pipe_data_out in cycle t+pipe_latency and accumulated at the end of that cycle.
REQ-032 On a valid result with sel<3: sum[sel][d] += zero-extended pipe_data_out dim d for d=0..4; count[sel] += 1.
REQ-033 On a valid result with sel=3: no accumulation, sel_err set.
REQ-034 Sums and counts SHALL wrap modulo 2^acc_width and 2^cnt_width, with no saturation.
REQ-035 DRAIN to DONE on the first cycle the shift register is all zero; done=1 for exactly that transition's following cycle, i.e. the first cycle in DONE.
REQ-036 DONE: results held stable; start SHALL begin a new pass exactly as in IDLE; cfg_we SHALL be ignored in DONE; done stays 0 after its single cycle.
REQ-037 in_ready=0 in IDLE, DRAIN and DONE; cfg_we outside IDLE SHALL have no effect.

Reset
REQ-038 rst_n=0 at a clock edge SHALL force IDLE, clear all centroids, sums, counts, issued, the shift register and sel_err; in_ready=0, busy=0, done=0.
REQ-039 Reset mid-RUN or mid-DRAIN SHALL discard in-flight results; no done pulse is produced.

Verification
REQ-040 Write centroids (0,0,0,0,0), (100,...), (200,...); start with num_points=3; stream (1,...), (99,...), (210,...) -> done once; rd_cnt k0,k1,k2 = 1,1,1; sum[2][0]=210.
REQ-041 num_points=0, start -> busy high 2 cycles, done pulse, all counts 0, in_ready never 1.
REQ-042 num_points=4 with in_valid toggling every other cycle -> exactly 4 transfers, in_ready drops after the 4th, done pulse pipe_latency+1 cycles after the last transfer.
REQ-043 Force pipe_sel=3 on one valid result -> sel_err=1, that point is excluded from counts, the other counts are correct.
REQ-044 Assert rst_n=0 during DRAIN -> next cycle IDLE, all outputs 0, no done pulse; a subsequent pass gives correct results.
REQ-045 cfg_we during RUN with new data -> pipe_centroids unchanged.
